// File: rtl/gold_silver_ctrl_pkg.sv
// Shared constants, golden-packet id type and LFSR step for the MinBD priority controller.
package gold_silver_ctrl_pkg;

  localparam int NUM_PORT   = 4;
  localparam int NODE_NUM   = 16;
  localparam int WIDTH_NODE = 4;
  localparam int WIDTH_SEQ  = 3;
  localparam int EPOCH_LEN  = 64;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [WIDTH_NODE-1:0] node;
    logic [WIDTH_SEQ-1:0]  seq;
  } golden_id_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first request at or above ptr_i, wrapping.
module rr_pick4
  import gold_silver_ctrl_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] grant_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic       found_s;
  logic [1:0] pos_s;
  logic [1:0] idx_s;

  // Scan the four positions starting at the pointer; the first hit wins.
  always_comb begin
    found_s = 1'b0;
    idx_s   = 2'b00;
    pos_s   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      pos_s = ptr_i + 2'(k);
      if (!found_s && req_i[pos_s]) begin
        found_s = 1'b1;
        idx_s   = pos_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Expand the winning index to a one-hot grant.
  always_comb begin
    if (found_s) begin
      grant_o = 4'b0001 << idx_s;
    end else begin
      grant_o = 4'b0000;
    end
  end

  assign idx_o = idx_s;
  assign any_o = found_s;

endmodule

// File: rtl/gold_silver_ctrl.sv
// Golden-epoch keeper, gold/silver tagger and tie-break LFSR feeding the MinBD arbiter tree.
module gold_silver_ctrl #(
  parameter int          NUM_PORT   = gold_silver_ctrl_pkg::NUM_PORT,
  parameter int          NODE_NUM   = gold_silver_ctrl_pkg::NODE_NUM,
  parameter int          WIDTH_NODE = gold_silver_ctrl_pkg::WIDTH_NODE,
  parameter int          WIDTH_SEQ  = gold_silver_ctrl_pkg::WIDTH_SEQ,
  parameter int          EPOCH_LEN  = gold_silver_ctrl_pkg::EPOCH_LEN,
  parameter logic [15:0] LFSR_SEED  = gold_silver_ctrl_pkg::LFSR_SEED
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [NUM_PORT-1:0]            vld_vec,
  input  logic [NUM_PORT*WIDTH_NODE-1:0] src_vec,
  input  logic [NUM_PORT*WIDTH_SEQ-1:0]  seq_vec,
  output logic [NUM_PORT-1:0]            gold_vec,
  output logic [NUM_PORT-1:0]            silver_vec,
  output logic [1:0]                     rand_num,
  output logic [WIDTH_NODE-1:0]          golden_node,
  output logic [WIDTH_SEQ-1:0]           golden_seq,
  output logic                           epoch_tick
);
  import gold_silver_ctrl_pkg::*;

  localparam int                    CNT_W     = $clog2(EPOCH_LEN);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(EPOCH_LEN - 1);
  localparam logic [WIDTH_NODE-1:0] NODE_LAST = WIDTH_NODE'(NODE_NUM - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]           SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [CNT_W-1:0]      epoch_cnt_q, epoch_cnt_d;
  logic [WIDTH_NODE-1:0] node_q, node_d;
  logic [WIDTH_SEQ-1:0]  seq_q, seq_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  tick_q, tick_d;

  logic [NUM_PORT-1:0]   cand_s;
  logic [3:0]            grant_s;
  logic [1:0]            win_idx_s;
  logic                  win_any_s;

  // Tag every valid flit belonging to the current golden packet.
  always_comb begin
    gold_vec = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (vld_vec[i]
          && (src_vec[i*WIDTH_NODE +: WIDTH_NODE] == node_q)
          && (seq_vec[i*WIDTH_SEQ +: WIDTH_SEQ] == seq_q)) begin
        gold_vec[i] = 1'b1;
      end else begin
        gold_vec[i] = 1'b0;
      end
    end
  end

  assign cand_s = vld_vec & ~gold_vec;

  rr_pick4 u_rr_pick4 (
    .req_i   (cand_s),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s),
    .idx_o   (win_idx_s),
    .any_o   (win_any_s)
  );

  assign silver_vec = grant_s;

  // Epoch counter and golden id advance; the golden node only moves when seq rolls over.
  always_comb begin
    epoch_cnt_d = epoch_cnt_q;
    node_d      = node_q;
    seq_d       = seq_q;
    tick_d      = tick_q;
    if (en) begin
      if (epoch_cnt_q == CNT_LAST) begin
        epoch_cnt_d = '0;
        tick_d      = 1'b1;
        seq_d       = seq_q + WIDTH_SEQ'(1);
        if (&seq_q) begin
          if (node_q == NODE_LAST) begin
            node_d = '0;
          end else begin
            node_d = node_q + WIDTH_NODE'(1);
          end
        end else begin
          node_d = node_q;
        end
      end else begin
        epoch_cnt_d = epoch_cnt_q + CNT_W'(1);
        tick_d      = 1'b0;
      end
    end else begin
      epoch_cnt_d = epoch_cnt_q;
    end
  end

  // LFSR step and round-robin pointer update, both gated by en.
  always_comb begin
    lfsr_d   = lfsr_q;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (win_any_s) begin
        rr_ptr_d = win_idx_s + 2'd1;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epoch_cnt_q <= '0;
      node_q      <= '0;
      seq_q       <= '0;
      lfsr_q      <= SEED_EFF;
      rr_ptr_q    <= 2'd0;
      tick_q      <= 1'b0;
    end else begin
      epoch_cnt_q <= epoch_cnt_d;
      node_q      <= node_d;
      seq_q       <= seq_d;
      lfsr_q      <= lfsr_d;
      rr_ptr_q    <= rr_ptr_d;
      tick_q      <= tick_d;
    end
  end

  assign rand_num    = lfsr_q[1:0];
  assign golden_node = node_q;
  assign golden_seq  = seq_q;
  assign epoch_tick  = tick_q;

endmodule

// File: tb/tb_gold_silver_ctrl.sv
// Directed self-checking bench for gold_silver_ctrl with an 8-cycle epoch.
module tb_gold_silver_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  vld_vec;
  logic [15:0] src_vec;
  logic [11:0] seq_vec;
  logic [3:0]  gold_vec;
  logic [3:0]  silver_vec;
  logic [1:0]  rand_num;
  logic [3:0]  golden_node;
  logic [2:0]  golden_seq;
  logic        epoch_tick;

  int compared;
  int mismatched;

  gold_silver_ctrl #(.EPOCH_LEN(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .vld_vec     (vld_vec),
    .src_vec     (src_vec),
    .seq_vec     (seq_vec),
    .gold_vec    (gold_vec),
    .silver_vec  (silver_vec),
    .rand_num    (rand_num),
    .golden_node (golden_node),
    .golden_seq  (golden_seq),
    .epoch_tick  (epoch_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; vld_vec = 4'b0000; src_vec = 16'h0000; seq_vec = 12'h000;
    #3;
    compared++;
    if (golden_node !== 4'd0) begin $display("FAIL reset_node got %0d exp 0", golden_node); mismatched++; end
    compared++;
    if (golden_seq !== 3'd0) begin $display("FAIL reset_seq got %0d exp 0", golden_seq); mismatched++; end
    compared++;
    if (rand_num !== 2'b01) begin $display("FAIL reset_rand got %b exp 01", rand_num); mismatched++; end
    compared++;
    if (epoch_tick !== 1'b0) begin $display("FAIL reset_tick got %b exp 0", epoch_tick); mismatched++; end
    compared++;
    if ({gold_vec, silver_vec} !== 8'h00) begin $display("FAIL reset_tags got %h exp 00", {gold_vec, silver_vec}); mismatched++; end
    step();
    reset = 1'b0;
  endtask

  task automatic test_epoch();
    logic [15:0] m;
    do_reset();
    en = 1'b1; vld_vec = 4'b0000;
    m = 16'hACE1;
    for (int c = 1; c <= 1024; c++) begin
      step();
      m = lfsr_model(m);
      compared++;
      if (epoch_tick !== ((c % 8) == 0)) begin $display("FAIL epoch_tick cyc %0d got %b exp %b", c, epoch_tick, (c % 8) == 0); mismatched++; end
      compared++;
      if (golden_seq !== 3'((c / 8) % 8)) begin $display("FAIL epoch_seq cyc %0d got %0d exp %0d", c, golden_seq, (c / 8) % 8); mismatched++; end
      compared++;
      if (golden_node !== 4'((c / 64) % 16)) begin $display("FAIL epoch_node cyc %0d got %0d exp %0d", c, golden_node, (c / 64) % 16); mismatched++; end
      compared++;
      if (rand_num !== m[1:0]) begin $display("FAIL epoch_rand cyc %0d got %b exp %b", c, rand_num, m[1:0]); mismatched++; end
    end
  endtask

  task automatic test_gold_match();
    do_reset();
    en = 1'b1; vld_vec = 4'b1111;
    src_vec = {4'd0, 4'd0, 4'd5, 4'd0};
    seq_vec = {3'd0, 3'd1, 3'd0, 3'd0};
    #1;
    compared++;
    if (gold_vec !== 4'b1001) begin $display("FAIL gold_match got %b exp 1001", gold_vec); mismatched++; end
    compared++;
    if (silver_vec !== 4'b0010) begin $display("FAIL silver_ptr0 got %b exp 0010", silver_vec); mismatched++; end
    step();
    compared++;
    if (silver_vec !== 4'b0100) begin $display("FAIL silver_ptr2 got %b exp 0100", silver_vec); mismatched++; end
    compared++;
    if (gold_vec !== 4'b1001) begin $display("FAIL gold_hold got %b exp 1001", gold_vec); mismatched++; end
    step();
    compared++;
    if (silver_vec !== 4'b0010) begin $display("FAIL silver_ptr3_wrap got %b exp 0010", silver_vec); mismatched++; end
  endtask

  task automatic test_round_robin();
    do_reset();
    en = 1'b1; vld_vec = 4'b1111; src_vec = 16'hFFFF; seq_vec = 12'h000;
    #1;
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (silver_vec !== (4'b0001 << (k % 4))) begin $display("FAIL rr_seq step %0d got %b exp %b", k, silver_vec, 4'b0001 << (k % 4)); mismatched++; end
      compared++;
      if (gold_vec !== 4'b0000) begin $display("FAIL rr_nogold step %0d got %b exp 0000", k, gold_vec); mismatched++; end
      step();
    end
  endtask

  task automatic test_freeze();
    logic [15:0] m;
    logic [3:0]  fv_vld  [10] = '{4'b1111, 4'b0111, 4'b0110, 4'b0000, 4'b0100, 4'b0001, 4'b1001, 4'b0011, 4'b1010, 4'b1111};
    logic [15:0] fv_src  [10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF0, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic [3:0]  fv_gold [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0]  fv_silv [10] = '{4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0001, 4'b1000, 4'b1000};
    do_reset();
    en = 1'b1; vld_vec = 4'b1111; src_vec = 16'hFFFF; seq_vec = 12'h000;
    m = 16'hACE1;
    for (int k = 0; k < 3; k++) begin
      step();
      m = lfsr_model(m);
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vld_vec = fv_vld[k]; src_vec = fv_src[k];
      #1;
      compared++;
      if (gold_vec !== fv_gold[k]) begin $display("FAIL freeze_gold vec %0d got %b exp %b", k, gold_vec, fv_gold[k]); mismatched++; end
      compared++;
      if (silver_vec !== fv_silv[k]) begin $display("FAIL freeze_silver vec %0d got %b exp %b", k, silver_vec, fv_silv[k]); mismatched++; end
      step();
      compared++;
      if (rand_num !== m[1:0]) begin $display("FAIL freeze_rand vec %0d got %b exp %b", k, rand_num, m[1:0]); mismatched++; end
      compared++;
      if ({golden_node, golden_seq, epoch_tick} !== 8'h00) begin $display("FAIL freeze_golden vec %0d got %h exp 00", k, {golden_node, golden_seq, epoch_tick}); mismatched++; end
    end
    en = 1'b1; vld_vec = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      step();
      compared++;
      if (epoch_tick !== (k == 5)) begin $display("FAIL resume_tick step %0d got %b exp %b", k, epoch_tick, k == 5); mismatched++; end
      compared++;
      if (golden_seq !== ((k == 5) ? 3'd1 : 3'd0)) begin $display("FAIL resume_seq step %0d got %0d exp %0d", k, golden_seq, (k == 5) ? 1 : 0); mismatched++; end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; vld_vec = 4'b0000;
    for (int k = 0; k < 8; k++) step();
    compared++;
    if ({epoch_tick, golden_seq} !== 4'b1001) begin $display("FAIL pre_reset_state got %b exp 1001", {epoch_tick, golden_seq}); mismatched++; end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (golden_node !== 4'd0) begin $display("FAIL async_node got %0d exp 0", golden_node); mismatched++; end
    compared++;
    if (golden_seq !== 3'd0) begin $display("FAIL async_seq got %0d exp 0", golden_seq); mismatched++; end
    compared++;
    if (rand_num !== 2'b01) begin $display("FAIL async_rand got %b exp 01", rand_num); mismatched++; end
    compared++;
    if (epoch_tick !== 1'b0) begin $display("FAIL async_tick got %b exp 0", epoch_tick); mismatched++; end
    step();
    reset = 1'b0;
  endtask

  task automatic test_lfsr_long();
    logic [15:0] m;
    int bad;
    do_reset();
    en = 1'b1; vld_vec = 4'b0000;
    m = 16'hACE1;
    bad = 0;
    for (int c = 0; c < 65535; c++) begin
      step();
      m = lfsr_model(m);
      if (rand_num !== m[1:0]) bad++;
    end
    compared++;
    if (bad !== 0) begin $display("FAIL lfsr_track got %0d bad cycles exp 0", bad); mismatched++; end
    compared++;
    if (rand_num !== 2'b01) begin $display("FAIL lfsr_period got %b exp 01", rand_num); mismatched++; end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_epoch();
    test_gold_match();
    test_round_robin();
    test_freeze();
    test_async_reset();
    test_lfsr_long();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
